// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage (master) and memory (slave).
interface fetch_unit_if;
    logic        read;
    logic [31:0] address;
    logic [31:0] rdata;
    logic        resp;

    modport master (output read, output address, input rdata, input resp);
    modport slave  (input read, input address, output rdata, output resp);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request FSM and single-entry output buffer.
// Define FETCH_JAL_SHORTCUT_EN to follow JAL targets directly at fetch time.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_in,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         ir_out,
    output logic [31:0]         pc_out,
    output logic                valid_out,
    output logic                flush_out
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {REQ, IDLE, SQUASH} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] buf_ir_q, buf_ir_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] next_pc;
    logic        read_w;
    logic [31:0] address_w;

`ifdef FETCH_JAL_SHORTCUT_EN
    logic [31:0] jal_imm;
    logic        is_jal;
    assign jal_imm = {{11{imem.rdata[31]}}, imem.rdata[31], imem.rdata[19:12],
                      imem.rdata[20], imem.rdata[30:21], 1'b0};
    assign is_jal  = (imem.rdata[6:0] == 7'b1101111);
    assign next_pc = is_jal ? (pc_q + jal_imm) : (pc_q + 32'd4);
`else
    assign next_pc = pc_q + 32'd4;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            hold_q      <= RESET_PC;
            buf_ir_q    <= NOP;
            buf_pc_q    <= 32'd0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_q      <= hold_d;
            buf_ir_q    <= buf_ir_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        buf_ir_d    = buf_ir_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;
        read_w      = 1'b0;
        address_w   = pc_q;

        case (state_q)
            REQ: begin
                read_w    = 1'b1;
                address_w = pc_q;
                if (imem.resp) begin
                    buf_ir_d    = imem.rdata;
                    buf_pc_d    = pc_q;
                    buf_valid_d = 1'b1;
                    pc_d        = next_pc;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (buf_valid_q && !stall_in) begin
                    buf_valid_d = 1'b0;
                    state_d     = REQ;
                end
            end
            SQUASH: begin
                read_w    = 1'b1;
                address_w = hold_q;
                if (imem.resp) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        // A live request cannot be abandoned, so an unanswered one is drained in SQUASH.
        if (redirect) begin
            pc_d        = redirect_pc;
            buf_valid_d = 1'b0;
            case (state_q)
                REQ: begin
                    if (imem.resp) begin
                        state_d = REQ;
                    end else begin
                        state_d = SQUASH;
                        hold_d  = pc_q;
                    end
                end
                IDLE:    state_d = REQ;
                SQUASH:  state_d = SQUASH;
                default: state_d = REQ;
            endcase
        end
    end

    assign imem.read    = read_w;
    assign imem.address = address_w;
    assign valid_out    = buf_valid_q;
    assign ir_out       = buf_valid_q ? buf_ir_q : NOP;
    assign pc_out       = buf_valid_q ? buf_pc_q : 32'd0;
    assign flush_out    = redirect;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios, then random traffic against a
// queue of expected (pc, instruction) deliveries.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        flush_out;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h00000060)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_in   (stall_in),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem       (bus),
        .ir_out     (ir_out),
        .pc_out     (pc_out),
        .valid_out  (valid_out),
        .flush_out  (flush_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          deliveries = 0;
    int          idle_cycles = 0;
    logic        sb_on = 1'b0;
    fetch_t      exp_q[$];
    logic [31:0] last_pc;

    // Memory image: any word-aligned address maps to a deterministic non-JAL instruction.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return {h[31:7], 7'b0010011};
    endfunction

    task automatic push_exp(input logic [31:0] pc);
        fetch_t e;
        e.pc = pc;
        e.ir = mem_word(pc);
        exp_q.push_back(e);
        last_pc = pc;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc,
                                 input logic rs, input logic [31:0] rdat);
        @(posedge clk);
        #1;
        stall_in    = st;
        redirect    = rd;
        redirect_pc = rpc;
        bus.resp    = rs;
        bus.rdata   = rdat;
    endtask

    // Monitor: compares presented instructions with the front of the expected queue.
    always @(negedge clk) begin
        if (sb_on && !rst) begin
            checkOutput("flush_out", {31'd0, flush_out}, {31'd0, redirect});
            if (!redirect) begin
                if (valid_out) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        checkOutput("sb_pc", pc_out, exp_q[0].pc);
                        checkOutput("sb_ir", ir_out, exp_q[0].ir);
                        if (!stall_in) begin
                            void'(exp_q.pop_front());
                            deliveries++;
                            idle_cycles = 0;
                        end
                    end
                end else begin
                    checkOutput("sb_nop_ir", ir_out, NOP);
                    checkOutput("sb_nop_pc", pc_out, 32'd0);
                end
            end
            idle_cycles++;
            if (idle_cycles > 300) begin
                checkOutput("sb_progress_timeout", 32'd1, 32'd0);
                idle_cycles = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] tgt;
        logic [31:0] jal_next;

        rst = 1'b1;
        stall_in = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        bus.resp = 1'b0;
        bus.rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_read", {31'd0, bus.read}, 32'd1);
        checkOutput("rst_addr", bus.address, 32'h60);
        checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("rst_ir", ir_out, NOP);
        checkOutput("rst_pc", pc_out, 32'd0);
        redirect = 1'b1;
        #1;
        checkOutput("rst_flush", {31'd0, flush_out}, 32'd1);
        redirect = 1'b0;
        rst = 1'b0;

        // First fetch: response one cycle after reset release.
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("first_addr", bus.address, 32'h60);
        applyStimulus(0, 0, 0, 1, 32'h00A00093);
        @(negedge clk);
        checkOutput("resp_addr", bus.address, 32'h60);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("stall_valid", {31'd0, valid_out}, 32'd1);
            checkOutput("stall_ir", ir_out, 32'h00A00093);
            checkOutput("stall_pc", pc_out, 32'h60);
            checkOutput("stall_read", {31'd0, bus.read}, 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("consume_valid", {31'd0, valid_out}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("next_read", {31'd0, bus.read}, 32'd1);
        checkOutput("next_addr", bus.address, 32'h64);
        checkOutput("next_valid", {31'd0, valid_out}, 32'd0);
        checkOutput("next_ir", ir_out, NOP);

        // Redirect to 0x80 together with a response, then squash while 0x80 is pending.
        applyStimulus(0, 1, 32'h80, 1, mem_word(32'h64));
        @(negedge clk);
        checkOutput("redir_flush", {31'd0, flush_out}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("redir80_addr", bus.address, 32'h80);
        checkOutput("redir80_valid", {31'd0, valid_out}, 32'd0);
        applyStimulus(0, 1, 32'h200, 0, 0);
        @(negedge clk);
        checkOutput("squash_flush", {31'd0, flush_out}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("squash_read", {31'd0, bus.read}, 32'd1);
            checkOutput("squash_addr", bus.address, 32'h80);
            checkOutput("squash_valid", {31'd0, valid_out}, 32'd0);
        end
        applyStimulus(0, 0, 0, 1, 32'hDEAD0013);
        @(negedge clk);
        checkOutput("squash_resp_addr", bus.address, 32'h80);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("after_squash_addr", bus.address, 32'h200);
        checkOutput("after_squash_valid", {31'd0, valid_out}, 32'd0);
        applyStimulus(0, 0, 0, 1, 32'h11100013);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t200_valid", {31'd0, valid_out}, 32'd1);
        checkOutput("t200_pc", pc_out, 32'h200);
        checkOutput("t200_ir", ir_out, 32'h11100013);

        // Redirect coinciding with a response drops the data.
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t204_addr", bus.address, 32'h204);
        applyStimulus(0, 1, 32'h300, 1, 32'h22200013);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("t300_addr", bus.address, 32'h300);
        checkOutput("t300_valid", {31'd0, valid_out}, 32'd0);

        // Sequential wrap at the top of the address space.
        applyStimulus(0, 1, 32'hFFFFFFFC, 1, 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 32'h33300013);
        @(negedge clk);
        checkOutput("wrap_req_addr", bus.address, 32'hFFFFFFFC);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wrap_pc", pc_out, 32'hFFFFFFFC);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wrap_next_addr", bus.address, 32'h0);

        // JAL with immediate +0x100 fetched at 0x60.
`ifdef FETCH_JAL_SHORTCUT_EN
        jal_next = 32'h160;
`else
        jal_next = 32'h64;
`endif
        applyStimulus(0, 1, 32'h60, 1, 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 32'h1000006F);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("jal_ir", ir_out, 32'h1000006F);
        checkOutput("jal_pc", pc_out, 32'h60);
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("jal_next_addr", bus.address, jal_next);

        // Random traffic checked by the scoreboard monitor.
        @(posedge clk);
        #1;
        rst = 1'b1;
        stall_in = 1'b0;
        redirect = 1'b0;
        bus.resp = 1'b0;
        exp_q.delete();
        push_exp(32'h60);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles = 0;
        sb_on = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            while (exp_q.size() < 4) push_exp(last_pc + 32'd4);
            stall_in = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 19) == 0);
            if (redirect) begin
                if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFF4;
                else tgt = $urandom() & 32'hFFFFFFFC;
                redirect_pc = tgt;
                exp_q.delete();
                push_exp(tgt);
            end
            bus.resp = bus.read && ($urandom_range(0, 1) == 0);
            bus.rdata = bus.resp ? mem_word(bus.address) : $urandom();
        end
        @(negedge clk);
        sb_on = 1'b0;
        checkOutput("random_deliveries_min", {31'd0, (deliveries >= 100)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: owns the program counter, initiates reads on the instruction-memory port and hands each fetched instruction word and its PC to the decode pipeline register. It drives that register's load and flush inputs, and accepts control-flow redirects from execute. A single-entry output buffer decouples memory latency from downstream stalls.

## Interface
Parameters:
- RESET_PC, 32'h00000060, PC fetched first after reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall_in  in  1  downstream cannot accept this cycle
- redirect  in  1  execute resolved a control-flow change
- redirect_pc  in  32  target PC when redirect=1
- imem_read  out  1  instruction read request
- imem_address  out  32  read address, word aligned
- imem_rdata  in  32  instruction word, valid when imem_resp=1
- imem_resp  in  1  read complete
- ir_out  out  32  buffered instruction word
- pc_out  out  32  PC of ir_out
- valid_out  out  1  ir_out/pc_out valid; drives decode-register load
- flush_out  out  1  squash decode-register contents; combinational copy of redirect

## Operation
- State: pc (32), buffer {ir, pc, valid}, FSM state in {REQ, IDLE, SQUASH}.
- REQ: imem_read=1, imem_address=pc. On imem_resp: buffer <= {imem_rdata, pc, 1}; pc <= next_pc; go IDLE.
- IDLE: imem_read=0. When valid_out && !stall_in (buffer consumed): buffer.valid <= 0, go REQ.
- SQUASH: imem_read=1, imem_address held at the abandoned address; on imem_resp discard data, go REQ. pc already holds redirect target.
- next_pc = pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Redirect (highest priority, any state): pc <= redirect_pc; buffer.valid <= 0; flush_out=1 same cycle.
  - REQ without imem_resp same cycle -> SQUASH (memory protocol forbids dropping a live request).
  - REQ with imem_resp same cycle -> response discarded, go REQ.
  - IDLE -> REQ. SQUASH stays SQUASH.
- Stall with buffer valid: ir_out/pc_out/valid_out held unchanged.
- ir_out=32'h00000013 (NOP) and pc_out=0 whenever buffer invalid.

## Timing
- Reset values: state=REQ, pc=RESET_PC, buffer.valid=0; outputs imem_read=1, imem_address=RESET_PC, valid_out=0, ir_out=32'h00000013, pc_out=0, flush_out=redirect.
- imem_address stable while imem_read=1 until the imem_resp cycle; imem_resp sampled in every cycle imem_read=1, including the first (zero-wait memory legal).
- Latency: imem_resp in cycle N -> valid_out=1 in cycle N+1.
- Throughput: at most one instruction per 2 cycles (consume in N+1 -> REQ in N+2).
- Reset asserted mid-request: immediate return to reset values; the in-flight response is not tracked — memory is reset with the same rst.

## Configuration
- FETCH_JAL_SHORTCUT_EN defined: on an accepted response with imem_rdata[6:0]=7'b1101111 (JAL), next_pc = pc + sign-extended J-immediate instead of pc+4; instruction still forwarded. Execute must suppress its redirect for JAL.
- Undefined: next_pc always pc+4; JAL resolved by execute via redirect.

## Test plan
- Reset release, memory answers 0x00A00093 one cycle later -> first address 0x60; valid_out=1 next cycle with ir_out=0x00A00093, pc_out=0x60; next request 0x64.
- stall_in=1 for 5 cycles with buffer valid -> outputs frozen, imem_read=0; release -> consumed, request to pc+4 next cycle.
- redirect to 0x200 while REQ at 0x80 waits (resp 3 cycles later) -> flush_out=1 that cycle, SQUASH holds address 0x80, response discarded, then request 0x200, valid_out never shows 0x80.
- redirect to 0x300 in same cycle as imem_resp -> data dropped, next cycle request 0x300.
- Sequential fetch from 0xFFFFFFFC -> next request 0x00000000.
- With FETCH_JAL_SHORTCUT_EN, JAL imm=+0x100 at 0x60 -> next request 0x160; without, next request 0x64.
